// File: rtl/dds_tone_meter.sv
// dds_tone_meter: measures period and peak codes of a sampled tone using hysteretic rising mid-scale crossings
module dds_tone_meter #(
   parameter int ADC_N = 10,
   parameter int HYST  = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [ADC_N-1:0] adc_in,
   input  logic             adc_valid,
   output logic [CNT_W-1:0] period_out,
   output logic [ADC_N-1:0] pk_max,
   output logic [ADC_N-1:0] pk_min,
   output logic             meas_valid,
   output logic             no_signal
);
   localparam int MID = 1 << (ADC_N - 1);
   localparam int TOP = (1 << ADC_N) - 1;
   localparam logic [ADC_N-1:0] TH_HI = ADC_N'((MID + HYST > TOP) ? TOP : MID + HYST);
   localparam logic [ADC_N-1:0] TH_LO = ADC_N'((MID - HYST < 0) ? 0 : MID - HYST);
   typedef enum logic [1:0] {UNSYNC, LOW_WAIT, HIGH, LOW} state_t;
   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
   logic [ADC_N-1:0] trk_max, trk_min, max_n, min_n;
   logic             hi, lo, rise, tmo;
   assign hi      = adc_in >= TH_HI;
   assign lo      = adc_in <= TH_LO;
   assign cnt_inc = cnt + CNT_W'(1);
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      max_n   = trk_max;
      min_n   = trk_min;
      rise    = 1'b0;
      tmo     = 1'b0;
      if (adc_valid) begin
         case (state)
            UNSYNC:   state_n = lo ? LOW_WAIT : UNSYNC;
            LOW_WAIT: if (hi) begin
               state_n = HIGH;
               cnt_n   = CNT_W'(1);
               max_n   = adc_in;
               min_n   = adc_in;
            end
            default: if (state == LOW && hi) begin
               rise    = 1'b1;
               state_n = HIGH;
               cnt_n   = CNT_W'(1);
               max_n   = adc_in;
               min_n   = adc_in;
            end else if (cnt_inc == '1) begin
               // lost lock: too long without a rising crossing
               tmo     = 1'b1;
               state_n = UNSYNC;
               cnt_n   = '0;
            end else begin
               state_n = (state == HIGH && lo) ? LOW : state;
               cnt_n   = cnt_inc;
               max_n   = (adc_in > trk_max) ? adc_in : trk_max;
               min_n   = (adc_in < trk_min) ? adc_in : trk_min;
            end
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= UNSYNC;
         cnt        <= '0;
         trk_max    <= '0;
         trk_min    <= '0;
         period_out <= '0;
         pk_max     <= '0;
         pk_min     <= '0;
         meas_valid <= 1'b0;
         no_signal  <= 1'b1;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         trk_max    <= max_n;
         trk_min    <= min_n;
         meas_valid <= rise;
         if (rise) begin
            period_out <= cnt;
            pk_max     <= trk_max;
            pk_min     <= trk_min;
            no_signal  <= 1'b0;
         end else if (tmo) begin
            no_signal  <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_dds_tone_meter.sv
// tb_dds_tone_meter: table-driven tone rows plus hand sequences, scored through an expected-result queue
module tb_dds_tone_meter;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [9:0]  adc_in = '0;
   logic        adc_valid = 1'b0;
   logic [15:0] period_out;
   logic [9:0]  pk_max, pk_min;
   logic        meas_valid, no_signal;

   dds_tone_meter dut (
      .clk(clk), .rst(rst), .adc_in(adc_in), .adc_valid(adc_valid),
      .period_out(period_out), .pk_max(pk_max), .pk_min(pk_min),
      .meas_valid(meas_valid), .no_signal(no_signal)
   );

   always #5 clk = ~clk;

   typedef struct {int period; int mx; int mn;} exp_t;
   typedef struct {int sq; int n; int lo; int hi; int div; int per;
                   int e_pulses; int e_space; int e_period; int e_max; int e_min;} vec_t;

   exp_t sb[$];
   vec_t tbl[5];
   int checks = 0, errors = 0;
   int cyc = 0, last_cyc = -1, space = 0, pulses = 0;
   int armed = 0, last_x = 0, w_max = 0, w_min = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && meas_valid) begin
         exp_t e;
         pulses++;
         if (last_cyc >= 0 && space > 0) chk("pulse_spacing", cyc - last_cyc, space);
         last_cyc = cyc;
         if (sb.size() == 0) chk("unexpected_pulse", 1, 0);
         else begin
            e = sb.pop_front();
            chk("period_out", int'(period_out), e.period);
            chk("pk_max", int'(pk_max), e.mx);
            chk("pk_min", int'(pk_min), e.mn);
         end
      end
   end

   function automatic logic [9:0] wave(input int sq, input int n, input int lo, input int hi, input int t);
      real c, a;
      int ph;
      if (sq != 0) return ((t % n) < n / 2) ? 10'(lo) : 10'(hi);
      ph = (t + n / 2) % n;
      c = (lo + hi) / 2.0;
      a = (hi - lo) / 2.0;
      return 10'($rtoi(c + a * $sin(6.283185307179586 * ph / n) + 0.5));
   endfunction

   task automatic drive(input logic [9:0] s, input logic v);
      @(negedge clk);
      adc_in = s;
      adc_valid = v;
   endtask

   task automatic idle(input int k);
      repeat (k) drive(10'd0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      adc_valid = 1'b1;
      adc_in = 10'd0;
      @(negedge clk);
      rst = 1'b0;
      adc_valid = 1'b0;
      armed = 0;
      pulses = 0;
      last_cyc = -1;
      sb.delete();
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_period"}, int'(period_out), 0);
      chk({tag, "_pk_max"}, int'(pk_max), 0);
      chk({tag, "_pk_min"}, int'(pk_min), 0);
      chk({tag, "_meas_valid"}, int'(meas_valid), 0);
      chk({tag, "_no_signal"}, int'(no_signal), 1);
   endtask

   // expected crossings come from the waveform phase, windows from the driven samples
   task automatic tone(input int sq, input int n, input int lo, input int hi,
                       input int div, input int t0, input int t1);
      logic [9:0] s;
      int x;
      for (int t = t0; t < t1; t++) begin
         s = wave(sq, n, lo, hi, t);
         x = (sq != 0) ? int'(t % n == n / 2) : int'((t + n / 2) % n == 1);
         if (x != 0) begin
            if (armed != 0) sb.push_back('{t - last_x, w_max, w_min});
            armed = 1;
            last_x = t;
            w_max = int'(s);
            w_min = int'(s);
         end else if (armed != 0) begin
            w_max = (int'(s) > w_max) ? int'(s) : w_max;
            w_min = (int'(s) < w_min) ? int'(s) : w_min;
         end
         drive(s, 1'b1);
         for (int k = 1; k < div; k++) drive((t % 2 != 0) ? 10'd1023 : 10'd0, 1'b0);
      end
   endtask

   initial begin
      tbl[0] = '{0, 64, 0,   1023, 1, 5, 4, 64,  64, 1023, 0};
      tbl[1] = '{0, 64, 0,   1023, 3, 5, 4, 192, 64, 1023, 0};
      tbl[2] = '{1, 20, 0,   1023, 1, 5, 4, 20,  20, 1023, 0};
      tbl[3] = '{0, 32, 300, 724,  1, 4, 3, 32,  32, 724,  300};
      tbl[4] = '{0, 32, 100, 924,  2, 4, 3, 64,  32, 924,  100};

      do_reset();
      check_reset_vals("reset");

      for (int i = 0; i < 5; i++) begin
         do_reset();
         space = tbl[i].e_space;
         tone(tbl[i].sq, tbl[i].n, tbl[i].lo, tbl[i].hi, tbl[i].div, 0, tbl[i].n * tbl[i].per);
         idle(3);
         chk($sformatf("row%0d_pulses", i), pulses, tbl[i].e_pulses);
         chk($sformatf("row%0d_sb_left", i), sb.size(), 0);
         chk($sformatf("row%0d_period", i), int'(period_out), tbl[i].e_period);
         chk($sformatf("row%0d_pk_max", i), int'(pk_max), tbl[i].e_max);
         chk($sformatf("row%0d_pk_min", i), int'(pk_min), tbl[i].e_min);
         chk($sformatf("row%0d_no_signal", i), int'(no_signal), 0);
      end

      // hysteresis edges with inclusive thresholds, invalid garbage in between
      do_reset();
      space = 0;
      drive(10'd505, 1'b1); drive(10'd504, 1'b1); drive(10'd0, 1'b0);
      drive(10'd519, 1'b1); drive(10'd520, 1'b1); drive(10'd1023, 1'b0);
      drive(10'd505, 1'b1); drive(10'd510, 1'b1); drive(10'd600, 1'b1);
      drive(10'd0, 1'b0);   drive(10'd504, 1'b1); drive(10'd519, 1'b1);
      idle(2);
      chk("hyst_no_early_pulse", pulses, 0);
      sb.push_back('{6, 600, 504});
      drive(10'd520, 1'b1); drive(10'd505, 1'b1); drive(10'd1023, 1'b0);
      sb.push_back('{3, 520, 504});
      drive(10'd504, 1'b1); drive(10'd520, 1'b1);
      idle(3);
      chk("hyst_pulses", pulses, 2);
      chk("hyst_sb_left", sb.size(), 0);

      // reset in the middle of a period
      do_reset();
      tone(0, 64, 0, 1023, 1, 0, 128);
      tone(0, 64, 0, 1023, 1, 128, 158);
      idle(2);
      chk("midrst_pre_pulses", pulses, 1);
      do_reset();
      check_reset_vals("midrst");
      tone(0, 64, 0, 1023, 1, 0, 97);
      idle(2);
      chk("midrst_e0_silent", pulses, 0);
      tone(0, 64, 0, 1023, 1, 97, 98);
      idle(2);
      chk("midrst_first_pulse", pulses, 1);
      tone(0, 64, 0, 1023, 1, 98, 320);
      idle(3);
      chk("midrst_pulses", pulses, 4);
      chk("midrst_period", int'(period_out), 64);

      // in-band noise after lock runs into the timeout
      do_reset();
      tone(0, 64, 0, 1023, 1, 0, 192);
      begin
         int m;
         m = 65535 - (192 - last_x);
         for (int k = 0; k < m - 1; k++) drive(10'(512 + int'($urandom_range(10)) - 5), 1'b1);
         idle(2);
         chk("noise_still_locked", int'(no_signal), 0);
         drive(10'd515, 1'b1);
         idle(2);
      end
      chk("timeout_no_signal", int'(no_signal), 1);
      chk("timeout_pulses", pulses, 2);
      chk("timeout_period_hold", int'(period_out), 64);
      chk("timeout_pk_max_hold", int'(pk_max), 1023);
      chk("timeout_pk_min_hold", int'(pk_min), 0);
      chk("timeout_meas_valid", int'(meas_valid), 0);

      // amplitude step on a 32-sample sine
      do_reset();
      space = 32;
      tone(0, 32, 300, 724, 1, 0, 96);
      chk("step_small_pk_max", int'(pk_max), 724);
      chk("step_small_pk_min", int'(pk_min), 300);
      tone(0, 32, 100, 924, 1, 96, 192);
      idle(3);
      chk("step_pulses", pulses, 5);
      chk("step_sb_left", sb.size(), 0);
      chk("step_period", int'(period_out), 32);
      chk("step_pk_max", int'(pk_max), 924);
      chk("step_pk_min", int'(pk_min), 100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/dds_tone_meter.md
Name: dds_tone_meter

Overview:
Sample-stream tone analyser, the receive-side counterpart of the DDS sine generator. It consumes ADC (or looped-back DAC) codes and detects rising mid-scale crossings, using hysteresis to reject noise. Per signal period it reports the period in samples plus the maximum and minimum codes. It is used for closed-loop checking of the DDS output and for measuring external tones.

Parameters:
ADC_N, 10, sample width in bits; input is unsigned offset-binary, mid-scale = 2^(ADC_N-1).
HYST, 8, hysteresis half-width in codes; upper threshold TH_HI = MID+HYST, lower threshold TH_LO = MID-HYST.
CNT_W, 16, period counter width; the timeout limit is 2^CNT_W-1 samples.

Ports:
clk  input  1  system clock; all logic on its rising edge.
rst  input  1  synchronous, active-high reset.
adc_in  input  ADC_N  sample code, qualified by adc_valid.
adc_valid  input  1  sample strobe; a sample is accepted on any cycle with adc_valid=1.
period_out  output  CNT_W  samples between the last two rising crossings.
pk_max  output  ADC_N  largest code seen in the last measured period.
pk_min  output  ADC_N  smallest code seen in the last measured period.
meas_valid  output  1  one-cycle pulse when the three result outputs update.
no_signal  output  1  high when the block is not locked to a periodic signal.

Behaviour:
- Reset: all state clears; FSM goes to UNSYNC; counter = 0.
- Output reset values: period_out = 0, pk_max = 0, pk_min = 0, meas_valid = 0, no_signal = 1.
- Sample handling: only accepted samples (adc_valid=1) advance any state. Cycles with adc_valid=0 change nothing and never pulse meas_valid.
- UNSYNC: accepted sample <= TH_LO -> LOW_WAIT. Otherwise stay.
- LOW_WAIT: accepted sample >= TH_HI is the first rising crossing (E0) -> HIGH.
  - On E0: cnt <= 1; max/min trackers <= sample.
  - E0 produces no measurement.
- HIGH: accepted sample <= TH_LO -> LOW. Otherwise stay.
- LOW: accepted sample >= TH_HI is a rising crossing E -> HIGH.
  - On E: period_out <= cnt; pk_max <= tracker max; pk_min <= tracker min.
  - Trackers exclude sample E itself.
  - Then cnt <= 1 and trackers <= sample E.
  - meas_valid = 1 in the cycle after the acceptance of E (registered, latency 1); no_signal <= 0 in that same cycle.
- Non-crossing accepted samples in HIGH/LOW: cnt <= cnt+1; tracker max/min update by unsigned compare.
- Period definition: with crossings at accepted-sample indices i and j, period_out = j-i.
- Hysteresis: samples strictly between TH_LO and TH_HI never cause a transition. Both thresholds are inclusive.
- Timeout: in HIGH or LOW, when an accepted sample would take cnt to 2^CNT_W-1:
  - FSM -> UNSYNC; cnt <= 0; no_signal <= 1.
  - period_out, pk_max and pk_min hold their old values; no meas_valid.
- Output holding: results are only written on meas_valid.
- Threshold arithmetic: computed at ADC_N+1 bits, then clamped to [0, 2^ADC_N-1]. HYST=0 is legal, giving a single-threshold comparator.
- Reset mid-period: rst has priority over everything. The partial count is discarded; the next E0 does not report.
- rst and adc_valid in the same cycle: the sample is ignored.

Test Plan:
1. Rail-to-rail sine, 64 samples/period, codes 0..1023, adc_valid always 1, run 5 periods -> 4 meas_valid pulses spaced 64 cycles; each has period_out = 64, pk_max = 1023, pk_min = 0; no_signal falls on the first pulse.
2. Same sine with adc_valid = 1 every 3rd cycle -> period_out = 64 (sample-based); meas_valid pulses spaced 192 cycles.
3. Constant 512 ±5 noise (inside hysteresis, HYST=8) after lock from test 1 -> no meas_valid; after 65535 accepted samples no_signal = 1; old period_out/pk values still held.
4. Square wave 0/1023, 10 samples low then 10 high, repeated -> period_out = 20, pk_max = 1023, pk_min = 0; first crossing after reset produces no pulse.
5. rst asserted at sample 30 of a 64-sample sine, released 1 cycle later -> all outputs back to reset values; first meas_valid appears only after two full crossings, with period_out = 64.
6. Amplitude step from 300..724 to 100..924 on a 32-sample sine -> pk_max/pk_min track per period (724/300 then 924/100); period_out = 32 throughout.
